vx_dp_ram_reader: RTL and testbench

VX_DP_RAM_READER -- requirements
Module: VX_dp_ram_reader

---
 rtl/vx_dp_ram_reader.sv | 79 +++++++
 tb/tb_vx_dp_ram_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dp_ram_reader.sv
// vx_dp_ram_reader: tagged read front-end for a RAM port with a credit-guarded in-order response queue
module vx_dp_ram_reader #(
  parameter int DATAW       = 32,
  parameter int ADDRW       = 8,
  parameter int TAGW        = 4,
  parameter int RAM_LATENCY = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [TAGW-1:0]  req_tag,
  output logic             req_ready,
  output logic [ADDRW-1:0] ram_raddr,
  input  logic [DATAW-1:0] ram_rdata,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_data,
  output logic [TAGW-1:0]  rsp_tag,
  input  logic             rsp_ready,
  output logic             busy
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  if (RAM_LATENCY < 0 || RAM_LATENCY > 1 || RSP_DEPTH < RAM_LATENCY + 1 ||
      (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_params
    $error("vx_dp_ram_reader: RAM_LATENCY must be 0/1, RSP_DEPTH a power of 2 >= RAM_LATENCY+1");
  end

  logic            fire, enq, deq, stg_valid;
  logic [TAGW-1:0] enq_tag;
  logic [CW-1:0]   occ;
  logic [PW-1:0]   wptr, rptr;
  logic [DATAW+TAGW-1:0] mem [RSP_DEPTH];

  assign ram_raddr = req_addr;
  assign fire      = req_valid && req_ready;
  assign deq       = rsp_valid && rsp_ready;
  assign rsp_valid = occ != '0;
  assign busy      = rsp_valid || stg_valid;
  // Slots already promised to in-flight reads count against the queue, so data never arrives to a full queue
  assign req_ready = (({1'b0, occ} + {{CW{1'b0}}, stg_valid}) < (CW+1)'(RSP_DEPTH)) || deq;

  if (RAM_LATENCY == 0) begin : g_comb
    assign stg_valid = 1'b0;
    assign enq       = fire;
    assign enq_tag   = req_tag;
  end else begin : g_reg
    logic [TAGW-1:0] stg_tag;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) stg_valid <= 1'b0;
      else stg_valid <= fire;
    end
    always_ff @(posedge clk) begin
      if (fire) stg_tag <= req_tag;
    end
    assign enq     = stg_valid;
    assign enq_tag = stg_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      occ <= occ + CW'(enq) - CW'(deq);
      if (enq) wptr <= wptr == PW'(RSP_DEPTH - 1) ? '0 : wptr + PW'(1);
      if (deq) rptr <= rptr == PW'(RSP_DEPTH - 1) ? '0 : rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wptr] <= {ram_rdata, enq_tag};
  end

  assign {rsp_data, rsp_tag} = mem[rptr];
endmodule

// File: tb/tb_vx_dp_ram_reader.sv
// tb_vx_dp_ram_reader: instance 0 uses a registered RAM (latency 1), instance 1 a combinational RAM (latency 0)
module tb_vx_dp_ram_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic [7:0]  req_addr  [2];
  logic [3:0]  req_tag   [2];
  logic        req_ready [2];
  logic [7:0]  ram_raddr [2];
  logic [31:0] ram_rdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic [3:0]  rsp_tag   [2];
  logic        rsp_ready [2];
  logic        busy      [2];

  logic [31:0] ram [256];

  vx_dp_ram_reader #(.DATAW(32), .ADDRW(8), .TAGW(4), .RAM_LATENCY(1), .RSP_DEPTH(4)) u_l1 (
    .clk(clk), .reset(rst), .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_tag(req_tag[0]),
    .req_ready(req_ready[0]), .ram_raddr(ram_raddr[0]), .ram_rdata(ram_rdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .rsp_tag(rsp_tag[0]), .rsp_ready(rsp_ready[0]), .busy(busy[0]));

  vx_dp_ram_reader #(.DATAW(32), .ADDRW(8), .TAGW(4), .RAM_LATENCY(0), .RSP_DEPTH(4)) u_l0 (
    .clk(clk), .reset(rst), .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_tag(req_tag[1]),
    .req_ready(req_ready[1]), .ram_raddr(ram_raddr[1]), .ram_rdata(ram_rdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .rsp_tag(rsp_tag[1]), .rsp_ready(rsp_ready[1]), .busy(busy[1]));

  always @(posedge clk) ram_rdata[0] <= ram[ram_raddr[0]];
  assign ram_rdata[1] = ram[ram_raddr[1]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (cycle %0d)", k, nm, act, exp, cyc);
    end
  endtask

  // Model: every accepted request is a numbered entry that becomes visible L+1 cycles after its accept
  logic [31:0] md [2][4096];
  logic [3:0]  mt [2][4096];
  int          mr [2][4096];
  int          acc_n [2];
  int          pop_n [2];

  function automatic bit m_valid(int k);
    return pop_n[k] != acc_n[k] && mr[k][pop_n[k]] <= cyc;
  endfunction

  function automatic bit m_ready(int k);
    return (acc_n[k] - pop_n[k] < 4) || (m_valid(k) && rsp_ready[k]);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) pop_n[k] = acc_n[k];
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit a, p;
        a = req_valid[k] && m_ready(k);
        p = m_valid(k) && rsp_ready[k];
        if (a) begin
          md[k][acc_n[k]] = ram[req_addr[k]];
          mt[k][acc_n[k]] = req_tag[k];
          mr[k][acc_n[k]] = cyc + (k == 0 ? 2 : 1);
          acc_n[k]++;
        end
        if (p) pop_n[k]++;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        chk(k, "rsp_valid", rsp_valid[k], m_valid(k));
        chk(k, "req_ready", req_ready[k], m_ready(k));
        chk(k, "busy", busy[k], acc_n[k] != pop_n[k]);
        chk(k, "ram_raddr", ram_raddr[k], req_addr[k]);
        if (m_valid(k)) begin
          chk(k, "rsp_data", rsp_data[k], md[k][pop_n[k]]);
          chk(k, "rsp_tag", rsp_tag[k], mt[k][pop_n[k]]);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = '0;
      req_tag[k]   = '0;
      rsp_ready[k] = 1'b1;
    end
  endtask

  task automatic drain;
    int g;
    idle;
    g = 0;
    while ((busy[0] || busy[1]) && g < 50) begin
      step;
      g++;
    end
    chk(0, "drain within bound", g < 50, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g, s0, s1;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[5] = 32'hCAFE;
    for (int k = 0; k < 2; k++) begin
      acc_n[k] = 0;
      pop_n[k] = 0;
    end
    idle;
    repeat (3) step;
    chk(0, "reset rsp_valid", rsp_valid[0], 1'b0);
    chk(0, "reset busy", busy[0], 1'b0);
    chk(0, "reset req_ready", req_ready[0], 1'b1);
    rst = 1'b0;
    repeat (2) step;

    // Single latency-1 read returns exactly two cycles after accept
    req_valid[0] = 1'b1; req_addr[0] = 8'd5; req_tag[0] = 4'd3;
    @(negedge clk); chk(0, "single accept ready", req_ready[0], 1'b1);
    step; req_valid[0] = 1'b0;
    @(negedge clk); chk(0, "single N+1 rsp_valid", rsp_valid[0], 1'b0);
    step;
    @(negedge clk);
    chk(0, "single N+2 rsp_valid", rsp_valid[0], 1'b1);
    chk(0, "single N+2 rsp_data", rsp_data[0], 32'hCAFE);
    chk(0, "single N+2 rsp_tag", rsp_tag[0], 4'd3);
    step;
    @(negedge clk); chk(0, "single N+3 rsp_valid", rsp_valid[0], 1'b0);
    step;

    // Latency-0 back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      req_valid[1] = 1'b1; req_addr[1] = 8'(i); req_tag[1] = 4'(i);
      @(negedge clk);
      chk(1, "b2b req_ready", req_ready[1], 1'b1);
      if (i > 0) begin
        chk(1, "b2b rsp_valid", rsp_valid[1], 1'b1);
        chk(1, "b2b rsp_data", rsp_data[1], ram[i-1]);
        chk(1, "b2b rsp_tag", rsp_tag[1], 4'(i-1));
      end
      step;
    end
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk(1, "b2b last rsp_data", rsp_data[1], ram[7]);
    chk(1, "b2b last rsp_tag", rsp_tag[1], 4'd7);
    step;
    @(negedge clk); chk(1, "b2b after rsp_valid", rsp_valid[1], 1'b0);
    step;

    // Credit exhaustion with the consumer stalled, then one-cycle release
    rsp_ready[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid[0] = 1'b1; req_addr[0] = 8'(16 + c); req_tag[0] = 4'(c);
      @(negedge clk);
      if (req_ready[0]) n++;
      step;
    end
    chk(0, "credit accepts", n, 4);
    req_addr[0] = 8'd24; req_tag[0] = 4'd8;
    @(negedge clk); chk(0, "credit full req_ready", req_ready[0], 1'b0);
    step;
    rsp_ready[0] = 1'b1;
    @(negedge clk); chk(0, "credit bypass req_ready", req_ready[0], 1'b1);
    step;
    req_valid[0] = 1'b0;
    drain;
    chk(0, "credit all drained", acc_n[0] - pop_n[0], 0);

    // Randomized traffic on both latencies
    s0 = acc_n[0]; s1 = acc_n[1]; g = 0;
    while ((acc_n[0] - s0 < 1000 || acc_n[1] - s1 < 1000) && g < 20000) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = 8'($urandom);
        req_tag[k]   = 4'($urandom);
        rsp_ready[k] = 1'($urandom_range(0, 1));
      end
      step;
      g++;
    end
    chk(0, "random 1000 requests within bound", g < 20000, 1'b1);
    drain;

    // Reset in the middle of traffic discards everything outstanding
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[0] = 1'b1; req_addr[0] = 8'(40 + i); req_tag[0] = 4'(i + 1);
      @(negedge clk); chk(0, "pre-reset req_ready", req_ready[0], 1'b1);
      step;
    end
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk(0, "mid reset rsp_valid", rsp_valid[0], 1'b0);
    chk(0, "mid reset busy", busy[0], 1'b0);
    step;
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk(0, "no stale response", rsp_valid[0], 1'b0);
      step;
    end
    req_valid[0] = 1'b1; req_addr[0] = 8'd9; req_tag[0] = 4'd7;
    @(negedge clk); chk(0, "post-reset req_ready", req_ready[0], 1'b1);
    step;
    req_valid[0] = 1'b0;
    @(negedge clk); chk(0, "post-reset N+1 rsp_valid", rsp_valid[0], 1'b0);
    step;
    @(negedge clk);
    chk(0, "post-reset N+2 rsp_valid", rsp_valid[0], 1'b1);
    chk(0, "post-reset rsp_data", rsp_data[0], ram[9]);
    chk(0, "post-reset rsp_tag", rsp_tag[0], 4'd7);
    step;
    drain;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
